// File: rtl/serial_to_parallel.sv
// LSB-first deserializer with a one-entry valid/ready holding register.
// Optional sticky overrun flag: define SERIAL_TO_PARALLEL_OVERRUN_EN.
module serial_to_parallel #(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data,
  input  logic             shift_en,
  output logic [DEPTH-1:0] data_out,
  output logic             valid,
`ifdef SERIAL_TO_PARALLEL_OVERRUN_EN
  output logic             overrun,
`endif
  input  logic             ready
);

  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic {
    EMPTY,
    FULL
  } state_t;

  state_t           state;
  logic [DEPTH-1:0] shreg;
  logic [DEPTH-1:0] next_word;
  logic [CW-1:0]    cnt;
  logic             done;

  assign next_word = {data, shreg[DEPTH-1:1]};
  assign done      = shift_en && (cnt == LAST);
  assign valid     = (state == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      shreg    <= '0;
      cnt      <= '0;
      data_out <= '0;
`ifdef SERIAL_TO_PARALLEL_OVERRUN_EN
      overrun  <= 1'b0;
`endif
    end else begin
      if (shift_en) begin
        shreg <= next_word;
        cnt   <= done ? '0 : cnt + 1'b1;
      end
      unique case (state)
        EMPTY: begin
          if (done) begin
            data_out <= next_word;
            state    <= FULL;
          end
        end
        FULL: begin
          // a completing word can only replace one being consumed now
          if (done && ready) begin
            data_out <= next_word;
          end else if (done) begin
`ifdef SERIAL_TO_PARALLEL_OVERRUN_EN
            overrun <= 1'b1;
`endif
          end else if (ready) begin
            state <= EMPTY;
          end
        end
      endcase
    end
  end

endmodule
